// File: rtl/pc_sequencer.sv
// Program-counter unit: selects sequential, branch, jump or register targets and
// updates on the falling edge. Optional return-address stack under `PC_RAS_EN.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] immExt,
  input  logic [WIDTH-1:0] jumpAddr,
  input  logic [WIDTH-1:0] regAddr,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] addressOut,
  output logic [WIDTH-1:0] pcPlus,
  output logic             misalign,
  output logic             rasEmpty,
  output logic             rasFull
);

  logic [WIDTH-1:0] pc_q;
  logic             mis_q;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] target;

  assign addressOut = pc_q;
  assign misalign   = mis_q;
  assign pcPlus     = pc_q + WIDTH'(4);

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    top_q;
  logic [PW-1:0]    top_inc;
  logic [CW-1:0]    count_q;
  logic             do_pop;
  logic             do_push;

  assign top_inc  = top_q + PW'(1);
  assign rasEmpty = (count_q == '0);
  assign rasFull  = (count_q == CW'(RAS_DEPTH));
  assign do_pop   = (PCSrc == 2'b11) && ret && !rasEmpty;
  assign do_push  = call;
  assign reg_target = do_pop ? ras[top_q] : regAddr;

  // Push above the top; a push while full wraps onto the oldest slot.
  // Combined pop+push rewrites the top in place.
  always_ff @(negedge CLK) begin
    if (RST && PCWre && do_push) begin
      if (do_pop) ras[top_q]   <= pcPlus;
      else        ras[top_inc] <= pcPlus;
    end
  end

  always_ff @(negedge CLK) begin
    if (!RST) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (PCWre) begin
      if (do_push && !do_pop) begin
        top_q <= top_inc;
        if (!rasFull) count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        top_q   <= top_q - PW'(1);
        count_q <= count_q - CW'(1);
      end
    end
  end
`else
  localparam int unsigned unused_depth = RAS_DEPTH;
  logic unused_ras;

  assign unused_ras = call ^ ret;
  assign rasEmpty   = 1'b1;
  assign rasFull    = 1'b0;
  assign reg_target = regAddr;
`endif

  always_comb begin
    target = pcPlus;
    unique case (PCSrc)
      2'b00: target = pcPlus;
      2'b01: target = pcPlus + (immExt << 2);
      2'b10: target = jumpAddr;
      2'b11: target = reg_target;
    endcase
  end

  always_ff @(negedge CLK) begin
    if (!RST) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else if (PCWre) begin
      pc_q  <= {target[WIDTH-1:2], 2'b00};
      mis_q <= |target[1:0];
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, return-stack
// sequences (when PC_RAS_EN is defined) and randomized run against a queue model.
module tb_pc_sequencer;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RV   = 32'h100;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic         CLK;
  logic         RST;
  logic         PCWre;
  logic [1:0]   PCSrc;
  logic [W-1:0] immExt;
  logic [W-1:0] jumpAddr;
  logic [W-1:0] regAddr;
  logic         call;
  logic         ret;
  logic [W-1:0] addressOut;
  logic [W-1:0] pcPlus;
  logic         misalign;
  logic         rasEmpty;
  logic         rasFull;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PCWre(PCWre), .PCSrc(PCSrc), .immExt(immExt),
    .jumpAddr(jumpAddr), .regAddr(regAddr), .call(call), .ret(ret),
    .addressOut(addressOut), .pcPlus(pcPlus), .misalign(misalign),
    .rasEmpty(rasEmpty), .rasFull(rasFull)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  // Reference model: PC as a plain number, return stack as a bounded queue.
  logic [W-1:0] m_pc;
  logic         m_mis;
  logic [W-1:0] m_stack [$];

  task automatic model_edge();
    logic [W-1:0] pp;
    logic [W-1:0] tgt;
    if (!RST) begin
      m_pc  = RV;
      m_mis = 1'b0;
      m_stack.delete();
    end else if (PCWre) begin
      pp = m_pc + 32'd4;
      case (PCSrc)
        2'b00:   tgt = pp;
        2'b01:   tgt = pp + immExt * 32'd4;
        2'b10:   tgt = jumpAddr;
        default: begin
          if (RAS && ret && m_stack.size() > 0) tgt = m_stack.pop_back();
          else                                  tgt = regAddr;
        end
      endcase
      if (RAS && call) begin
        if (m_stack.size() == DEPTH) void'(m_stack.pop_front());
        m_stack.push_back(pp);
      end
      m_pc  = tgt & ~32'd3;
      m_mis = (tgt % 4) != 0;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("addressOut", addressOut, m_pc);
    check("pcPlus", pcPlus, m_pc + 32'd4);
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    check("rasEmpty", {31'd0, rasEmpty}, {31'd0, (m_stack.size() == 0)});
    check("rasFull", {31'd0, rasFull}, {31'd0, (m_stack.size() == DEPTH)});
  endtask

  task automatic drive(input logic rst, input logic we, input logic [1:0] src,
                       input logic [W-1:0] imm, input logic [W-1:0] jmp,
                       input logic [W-1:0] rg, input logic c, input logic r);
    RST = rst; PCWre = we; PCSrc = src; immExt = imm;
    jumpAddr = jmp; regAddr = rg; call = c; ret = r;
    @(negedge CLK);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic         rst;
    logic         we;
    logic [1:0]   src;
    logic [W-1:0] imm;
    logic [W-1:0] jmp;
    logic [W-1:0] rg;
    logic         c;
    logic         r;
    logic [W-1:0] exp_pc;
    logic         exp_mis;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic rst, input logic we, input logic [1:0] src,
                              input logic [W-1:0] imm, input logic [W-1:0] jmp,
                              input logic [W-1:0] rg, input logic r,
                              input logic [W-1:0] epc, input logic emis);
    vec_t v;
    v.rst = rst; v.we = we; v.src = src; v.imm = imm; v.jmp = jmp; v.rg = rg;
    v.c = 1'b0; v.r = r; v.exp_pc = epc; v.exp_mis = emis;
    return v;
  endfunction

  initial begin
    RST = 1'b0; PCWre = 1'b0; PCSrc = 2'b00; immExt = '0;
    jumpAddr = '0; regAddr = '0; call = 1'b0; ret = 1'b0;
    m_pc = '0; m_mis = 1'b0;

    tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h100, 0));
    tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h100, 0));
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 32'h104, 0));
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 32'h108, 0));
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 32'h10C, 0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'h200, 0, 0, 32'h200, 0));
    tbl.push_back(mk(1, 1, 2'b01, 32'hFFFFFFFE, 0, 0, 0, 32'h1FC, 0));
    tbl.push_back(mk(1, 0, 2'b01, 32'hFFFFFFFE, 0, 0, 0, 32'h1FC, 0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'h3006, 0, 0, 32'h3004, 1));
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 32'h3008, 0));
    tbl.push_back(mk(1, 1, 2'b01, 32'd3, 0, 0, 0, 32'h3018, 0));
    tbl.push_back(mk(1, 1, 2'b11, 0, 0, 32'h440, 1, 32'h440, 0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'hFFFFFFFE, 0, 0, 32'hFFFFFFFC, 1));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 32'hFFFFFFFC, 1));
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 2'b11, 0, 0, 32'h443, 0, 32'h440, 1));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h999, 0, 0, 32'h100, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].src, tbl[i].imm, tbl[i].jmp,
            tbl[i].rg, tbl[i].c, tbl[i].r);
      check($sformatf("vec%0d_pc", i), addressOut, tbl[i].exp_pc);
      check($sformatf("vec%0d_mis", i), {31'd0, misalign}, {31'd0, tbl[i].exp_mis});
    end
    check("default_rasEmpty", {31'd0, rasEmpty}, 32'd1);

`ifdef PC_RAS_EN
    drive(1, 1, 2'b10, 0, 32'h10, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      drive(1, 1, 2'b10, 0, 32'h10 * (k + 1), 0, 1, 0);
    check("five_push_full", {31'd0, rasFull}, 32'd1);
    drive(1, 0, 2'b11, 0, 0, 32'h900, 1, 1);
    check("hold_pc", addressOut, 32'h60);
    check("hold_full", {31'd0, rasFull}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 2'b11, 0, 0, 32'h900, 0, 1);
      check($sformatf("pop%0d", k), addressOut, 32'h54 - 32'h10 * k);
    end
    check("pops_empty", {31'd0, rasEmpty}, 32'd1);
    drive(1, 1, 2'b11, 0, 0, 32'h900, 0, 1);
    check("pop_on_empty", addressOut, 32'h900);
    drive(1, 1, 2'b10, 0, 32'h20, 0, 0, 0);
    drive(1, 1, 2'b10, 0, 32'h80, 0, 1, 0);
    drive(1, 1, 2'b11, 0, 0, 32'h900, 1, 1);
    check("callret_pc", addressOut, 32'h24);
    check("callret_notempty", {31'd0, rasEmpty}, 32'd0);
    drive(1, 1, 2'b11, 0, 0, 32'h900, 0, 1);
    check("callret_newtop", addressOut, 32'h84);
    check("callret_empty", {31'd0, rasEmpty}, 32'd1);
    drive(1, 1, 2'b10, 0, 32'h500, 0, 1, 0);
    drive(1, 1, 2'b01, 32'd1, 0, 0, 1, 1);
    drive(0, 0, 2'b00, 0, 0, 0, 1, 1);
    check("reset_clears_ras", {31'd0, rasEmpty}, 32'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] rj;
      logic [W-1:0] rr;
      rj = $urandom;
      rr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        rj[1:0] = 2'b00;
        rr[1:0] = 2'b00;
      end
      drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)), W'($signed($urandom_range(0, 64)) - 32),
            rj, rr, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
